// File: rtl/seven_segment_reader.sv
// ---------------------------------------------------------------------------
// seven_segment_reader
//   Receive side of a multiplexed, active-low 7-segment display bus. The
//   anode and segment lines are registered once, each digit's pattern must
//   stay unchanged for STABLE_CYCLES consecutive samples, and the stable
//   pattern is then decoded back to a hex value and stored for that digit.
//   Used next to the display driver to loop the display path back for
//   self-check.
//
// Parameters
//   NUM_DIGITS     number of anodes / digits scanned (1..8)
//   STABLE_CYCLES  identical samples needed before a pattern is decoded (2..255)
//
// Ports
//   clk          system clock, everything on the rising edge
//   reset        synchronous, active-high reset
//   an           anode enables, active-low, bit i selects digit i
//   seg          segment lines, active-low, bit0 = a ... bit6 = g
//   digits       decoded values, digit i at [4i+3:4i]
//   digit_valid  bit i set while digit i holds a decoded value
//   update       one-cycle pulse, a digit was written or blanked
//   update_idx   digit index of the latest update / pattern_err event
//   pattern_err  one-cycle pulse, a stable pattern was not a hex glyph
//   err_sticky   set by pattern_err, cleared only by reset
//   err_count    (only with SEG_READER_ERRCNT_EN) saturating count of
//                pattern_err pulses
//
// Build option
//   SEG_READER_ERRCNT_EN  adds the err_count output and its counter.
// ---------------------------------------------------------------------------
module seven_segment_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic [2:0]              update_idx,
  output logic                    pattern_err,
  output logic                    err_sticky
`ifdef SEG_READER_ERRCNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    DECODE,
    DONE
  } stateT;

  stateT                 state;
  stateT                 nextState;
  logic [NUM_DIGITS-1:0] anSample;
  logic [6:0]            segSample;
  logic [7:0]            runCount;
  logic [7:0]            nextCount;
  logic [2:0]            capIdx;
  logic [6:0]            capSeg;
  logic                  capture;
  logic                  fire;
  logic [3:0]            zeroCount;
  logic                  sampleSingle;
  logic [2:0]            sampleIdx;
  logic                  sameRun;
  logic                  runComplete;
  logic                  tableHit;
  logic [3:0]            tableValue;
  logic                  isBlank;

  // Single sampling stage: every decision below looks only at these
  // registered copies of the display bus, never at the raw inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      anSample  <= '0;
      segSample <= '0;
    end else begin
      anSample  <= an;
      segSample <= seg;
    end
  end

  // A sample belongs to one digit only when exactly one anode is driven
  // low; the position of that low bit is the digit index.
  always_comb begin
    zeroCount = '0;
    sampleIdx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!anSample[i]) begin
        zeroCount = zeroCount + 4'd1;
        sampleIdx = i[2:0];
      end
    end
    sampleSingle = (zeroCount == 4'd1);
  end

  // The current run continues only while both the digit and its pattern
  // match what was captured at the start of the run. The run is complete
  // on the sample that brings the count up to STABLE_CYCLES.
  assign sameRun     = (sampleIdx == capIdx) && (segSample == capSeg);
  assign runComplete = (({1'b0, runCount} + 9'd1) == 9'(STABLE_CYCLES));

  // State register plus the run bookkeeping that moves with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      runCount <= '0;
      capIdx   <= '0;
      capSeg   <= '0;
    end else begin
      state    <= nextState;
      runCount <= nextCount;
      if (capture) begin
        capIdx <= sampleIdx;
        capSeg <= segSample;
      end
    end
  end

  // Next-state logic. Any change of digit or pattern restarts the run at
  // one, so the counter can never wrap. The decode work itself is launched
  // on the TRACK->DECODE transition so that the result registers and the
  // event pulse appear together during the single DECODE cycle. DECODE
  // ignores its sample; DONE keeps a finished run from firing twice.
  always_comb begin
    nextState = state;
    nextCount = runCount;
    capture   = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (sampleSingle) begin
          nextState = TRACK;
          nextCount = 8'd1;
          capture   = 1'b1;
        end
      end
      TRACK: begin
        if (!sampleSingle) begin
          nextState = IDLE;
        end else if (!sameRun) begin
          nextCount = 8'd1;
          capture   = 1'b1;
        end else if (runComplete) begin
          nextState = DECODE;
          fire      = 1'b1;
        end else begin
          nextCount = runCount + 8'd1;
        end
      end
      DECODE: begin
        nextState = DONE;
      end
      DONE: begin
        if (!sampleSingle) begin
          nextState = IDLE;
        end else if (!sameRun) begin
          nextState = TRACK;
          nextCount = 8'd1;
          capture   = 1'b1;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Glyph table: the active-low patterns the display driver emits for
  // hex digits 0..F (lower-case b and d).
  always_comb begin
    tableHit   = 1'b0;
    tableValue = '0;
    case (capSeg)
      7'b1000000: begin tableHit = 1'b1; tableValue = 4'h0; end
      7'b1111001: begin tableHit = 1'b1; tableValue = 4'h1; end
      7'b0100100: begin tableHit = 1'b1; tableValue = 4'h2; end
      7'b0110000: begin tableHit = 1'b1; tableValue = 4'h3; end
      7'b0011001: begin tableHit = 1'b1; tableValue = 4'h4; end
      7'b0010010: begin tableHit = 1'b1; tableValue = 4'h5; end
      7'b0000010: begin tableHit = 1'b1; tableValue = 4'h6; end
      7'b1111000: begin tableHit = 1'b1; tableValue = 4'h7; end
      7'b0000000: begin tableHit = 1'b1; tableValue = 4'h8; end
      7'b0010000: begin tableHit = 1'b1; tableValue = 4'h9; end
      7'b0001000: begin tableHit = 1'b1; tableValue = 4'hA; end
      7'b0000011: begin tableHit = 1'b1; tableValue = 4'hB; end
      7'b1000110: begin tableHit = 1'b1; tableValue = 4'hC; end
      7'b0100001: begin tableHit = 1'b1; tableValue = 4'hD; end
      7'b0000110: begin tableHit = 1'b1; tableValue = 4'hE; end
      7'b0001110: begin tableHit = 1'b1; tableValue = 4'hF; end
      default: begin
        tableHit   = 1'b0;
        tableValue = '0;
      end
    endcase
  end

  assign isBlank = (capSeg == 7'b1111111);

  // Per-digit storage and event pulses. Only the captured digit is touched;
  // a blank pattern clears that digit's valid flag but keeps its old value,
  // and an unknown pattern raises the error without disturbing storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits      <= '0;
      digit_valid <= '0;
      update      <= 1'b0;
      update_idx  <= '0;
      pattern_err <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      update      <= 1'b0;
      pattern_err <= 1'b0;
      if (fire) begin
        update_idx <= capIdx;
        if (tableHit) begin
          update <= 1'b1;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capIdx == i[2:0]) begin
              digits[4*i +: 4] <= tableValue;
              digit_valid[i]   <= 1'b1;
            end
          end
        end else if (isBlank) begin
          update <= 1'b1;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capIdx == i[2:0]) begin
              digit_valid[i] <= 1'b0;
            end
          end
        end else begin
          pattern_err <= 1'b1;
          err_sticky  <= 1'b1;
        end
      end
    end
  end

`ifdef SEG_READER_ERRCNT_EN
  // Saturating count of unknown-pattern events; it parks at 255 rather
  // than wrapping back to a misleading small number.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (fire && !tableHit && !isBlank && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seven_segment_reader.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_reader
//   Self-checking bench for seven_segment_reader (NUM_DIGITS=4,
//   STABLE_CYCLES=4). The reference is a run-length model of the sampled
//   display bus: a run of identical single-digit samples that reaches
//   STABLE_CYCLES produces one event, decoded by searching the glyph table.
//   Directed scenarios come first, followed by randomly generated segments.
//   Builds with or without SEG_READER_ERRCNT_EN.
// ---------------------------------------------------------------------------
module tb_seven_segment_reader;

  localparam int ND = 4;
  localparam int SC = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [ND-1:0]   an;
  logic [6:0]      seg;
  logic [4*ND-1:0] digits;
  logic [ND-1:0]   digit_valid;
  logic            update;
  logic [2:0]      update_idx;
  logic            pattern_err;
  logic            err_sticky;
`ifdef SEG_READER_ERRCNT_EN
  logic [7:0]      err_count;
`endif

  int compared   = 0;
  int mismatched = 0;
  int dutEvents  = 0;

  logic [6:0] segTable [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic [3:0]    mDigits [ND];
  logic [ND-1:0] mValid;
  logic          mUpdate;
  logic          mErr;
  logic          mSticky;
  logic [2:0]    mIdx;
  int            mErrCnt;
  logic [ND-1:0] runAn;
  logic [6:0]    runSeg;
  int            runLen;

  seven_segment_reader #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .seg         (seg),
    .digits      (digits),
    .digit_valid (digit_valid),
    .update      (update),
    .update_idx  (update_idx),
    .pattern_err (pattern_err),
    .err_sticky  (err_sticky)
`ifdef SEG_READER_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Return the reference model to its power-on state.
  task automatic modelReset();
    for (int i = 0; i < ND; i++) mDigits[i] = '0;
    mValid  = '0;
    mUpdate = 1'b0;
    mErr    = 1'b0;
    mSticky = 1'b0;
    mIdx    = '0;
    mErrCnt = 0;
    runLen  = 0;
    runAn   = '0;
    runSeg  = '0;
  endtask

  // One clock edge of the reference: a run that has just reached SC
  // identical single-digit samples yields exactly one event now; then the
  // new sample either extends the run or starts a new one.
  task automatic modelEdge(input logic [ND-1:0] a, input logic [6:0] s);
    int   idx;
    logic found;
    logic [3:0] val;
    mUpdate = 1'b0;
    mErr    = 1'b0;
    if (runLen == SC && $countones(~runAn) == 1) begin
      idx   = 0;
      found = 1'b0;
      val   = '0;
      for (int i = 0; i < ND; i++) if (!runAn[i]) idx = i;
      for (int v = 0; v < 16; v++) begin
        if (segTable[v] == runSeg) begin
          found = 1'b1;
          val   = v[3:0];
        end
      end
      mIdx = idx[2:0];
      if (found) begin
        mDigits[idx] = val;
        mValid[idx]  = 1'b1;
        mUpdate      = 1'b1;
      end else if (runSeg == 7'b1111111) begin
        mValid[idx] = 1'b0;
        mUpdate     = 1'b1;
      end else begin
        mErr    = 1'b1;
        mSticky = 1'b1;
        if (mErrCnt < 255) mErrCnt++;
      end
    end
    if (runLen > 0 && a == runAn && s == runSeg) begin
      if (runLen < 1000) runLen++;
    end else begin
      runAn  = a;
      runSeg = s;
      runLen = 1;
    end
  endtask

  // Compare every output against the model for the current cycle.
  task automatic checkOutput();
    logic [4*ND-1:0] expDigits;
    for (int i = 0; i < ND; i++) expDigits[4*i +: 4] = mDigits[i];
    if (update || pattern_err) dutEvents++;
    checkValue("update", 32'(update), 32'(mUpdate));
    checkValue("pattern_err", 32'(pattern_err), 32'(mErr));
    checkValue("update_idx", 32'(update_idx), 32'(mIdx));
    checkValue("digits", 32'(digits), 32'(expDigits));
    checkValue("digit_valid", 32'(digit_valid), 32'(mValid));
    checkValue("err_sticky", 32'(err_sticky), 32'(mSticky));
`ifdef SEG_READER_ERRCNT_EN
    checkValue("err_count", 32'(err_count), 32'(mErrCnt));
`endif
  endtask

  // Hold one bus value for len edges, checking just after each edge.
  task automatic applyStimulus(input logic [ND-1:0] a, input logic [6:0] s,
                               input int len);
    an  = a;
    seg = s;
    repeat (len) begin
      @(posedge clk);
      modelEdge(a, s);
      #1;
      checkOutput();
    end
  endtask

  // Two reset edges with the bus idle, then release.
  task automatic applyReset();
    reset = 1'b1;
    an    = '1;
    seg   = '1;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkOutput();
    reset = 1'b0;
  endtask

  initial begin
    logic [ND-1:0] ra;
    logic [6:0]    rs;
    logic [ND-1:0] prevA;
    logic [6:0]    prevS;
    int            len;
    int            kind;

    reset = 1'b1;
    an    = '1;
    seg   = '1;
    modelReset();
    applyReset();
    $display("[TB] reset state checked");

    // Single digit 2 on digit 0, then held well beyond the decode point.
    dutEvents = 0;
    applyStimulus(4'b1110, 7'b0100100, 14);
    checkValue("t1_pulses", 32'(dutEvents), 32'd1);
    checkValue("t1_digit0", 32'(digits[3:0]), 32'h2);
    checkValue("t1_valid", 32'(digit_valid), 32'b0001);

    // Full scan of four digits showing 3, A, b, F.
    dutEvents = 0;
    applyStimulus(4'b1110, 7'b0110000, 8);
    applyStimulus(4'b1101, 7'b0001000, 8);
    applyStimulus(4'b1011, 7'b0000011, 8);
    applyStimulus(4'b0111, 7'b0001110, 8);
    checkValue("t2_pulses", 32'(dutEvents), 32'd4);
    checkValue("t2_digits", 32'(digits), 32'hFBA3);
    checkValue("t2_valid", 32'(digit_valid), 32'b1111);

    // Unknown pattern on digit 1.
    applyStimulus(4'b1101, 7'b0000001, 6);
    checkValue("t3_sticky", 32'(err_sticky), 32'd1);
    checkValue("t3_idx", 32'(update_idx), 32'd1);
    checkValue("t3_digits", 32'(digits), 32'hFBA3);
    checkValue("t3_valid", 32'(digit_valid), 32'b1111);

    // Glitching pattern and multi/no-anode buses never produce events.
    dutEvents = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b1110, (i % 2 == 0) ? 7'b1000000 : 7'b0000000, 3);
    end
    applyStimulus(4'b1100, 7'b0000000, 10);
    applyStimulus(4'b1111, 7'b0000000, 10);
    checkValue("t4_events", 32'(dutEvents), 32'd0);

    // Digit 2 shows d, then goes blank.
    applyStimulus(4'b1011, 7'b0100001, 6);
    checkValue("t5_valid_set", 32'(digit_valid[2]), 32'd1);
    applyStimulus(4'b1011, 7'b1111111, 6);
    checkValue("t5_valid_clr", 32'(digit_valid[2]), 32'd0);
    checkValue("t5_digit2", 32'(digits[11:8]), 32'hD);

    // Reset on the third stable cycle discards the run.
    applyStimulus(4'b1110, 7'b0110000, 2);
    reset = 1'b1;
    @(posedge clk);
    modelReset();
    #1;
    checkOutput();
    checkValue("t6_digits", 32'(digits), 32'd0);
    reset = 1'b0;
    applyStimulus(4'b1111, 7'b1111111, 3);
    $display("[TB] directed scenarios done");

    // Random segments; lengths avoid exactly SC so a DECODE cycle never
    // swallows the first sample of the following run.
    prevA = '1;
    prevS = '1;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      ra   = '1;
      if (kind <= 8) ra[$urandom_range(0, ND-1)] = 1'b0;
      else begin
        ra = ND'($urandom);
        if ($countones(~ra) == 1) ra = '1;
      end
      if (kind <= 6) rs = segTable[$urandom_range(0, 15)];
      else if (kind == 7) rs = 7'b1111111;
      else rs = 7'($urandom);
      if (ra == prevA && rs == prevS) rs = rs ^ 7'b0000001;
      len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, SC-1)
                                        : $urandom_range(SC+1, SC+6);
      applyStimulus(ra, rs, len);
      prevA = ra;
      prevS = rs;
    end
    applyStimulus(4'b1111, 7'b1111111, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
